fifo2write_region: RTL and testbench

- Write-side counterpart of the region-read-to-FIFO path.
- Drains a synchronous FIFO and writes its lines, in order, into a BRAM region as a sequence of consecutive addresses.
- The address sequence is repeated `iterations` times, restarting at the base address each pass; a later pass overwrites the earlier one.
- Sits between a compute-pipeline output FIFO and the region store; the controller launches it with `op_start`.

---
 rtl/fifo2write_region.sv | 152 +++++++++++++++
 tb/tb_fifo2write_region.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo2write_region.sv
// fifo2write_region: drains a synchronous FIFO into a BRAM region.
// Lines land at consecutive addresses starting at a base offset. The address
// sequence is replayed `iterations` times, so a later pass overwrites an
// earlier one. Reads are gated so the FIFO is never popped beyond the total
// line count of the operation.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for op_start; config is captured on launch
//   S_RUN    | issuing FIFO reads and writing returned lines to the region
//   S_FINISH | one-cycle op_done pulse, busy already low
module fifo2write_region #(
  parameter int WIDTH      = 512,
  parameter int LOG2_DEPTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_start,
  input  logic [31:0]           configreg,
  input  logic [15:0]           iterations,
  output logic                  fifo_re,
  input  logic                  fifo_rvalid,
  input  logic [WIDTH-1:0]      fifo_rdata,
  input  logic                  fifo_empty,
  output logic                  region_we,
  output logic [LOG2_DEPTH-1:0] region_waddr,
  output logic [WIDTH-1:0]      region_wdata,
  output logic                  busy,
  output logic                  op_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [LOG2_DEPTH-1:0] r_base;
  logic [15:0]           r_len;
  logic [15:0]           r_line_idx;
  logic [31:0]           r_total;
  logic [31:0]           r_issued;
  logic [31:0]           r_written;
  logic                  r_we;
  logic [LOG2_DEPTH-1:0] r_waddr;
  logic [WIDTH-1:0]      r_wdata;

  logic [31:0] w_total_in;
  logic        w_launch;
  logic        w_accept;
  logic        w_last_write;
  logic [15:0] w_line_inc;
  logic        w_unused_cfg;

  // LEN*ITER fits in 32 bits, so the product can never overflow.
  assign w_total_in   = 32'(configreg[31:16]) * 32'(iterations);
  assign w_launch     = (r_state == S_IDLE) && op_start;
  // Read data is only written while running; stray valids are dropped.
  assign w_accept     = (r_state == S_RUN) && fifo_rvalid;
  // The write currently presented is the final one of the operation.
  assign w_last_write = r_we && (r_written == (r_total - 32'd1));
  assign w_line_inc   = r_line_idx + 16'd1;
  // Only the low LOG2_DEPTH bits of the base field are meaningful.
  assign w_unused_cfg = ^configreg;

  assign region_we    = r_we;
  assign region_waddr = r_waddr;
  assign region_wdata = r_wdata;

  // State register with synchronous reset; reset beats a coincident op_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: an empty operation skips RUN and completes immediately.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (op_start) begin
          w_state_next = (w_total_in == 32'd0) ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last_write) begin
          w_state_next = S_FINISH;
        end
      end
      S_FINISH: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Status outputs and read issue; the issued-count gate prevents over-reads.
  always_comb begin
    busy    = (r_state == S_RUN);
    op_done = (r_state == S_FINISH);
    fifo_re = (r_state == S_RUN) && !fifo_empty && (r_issued < r_total);
  end

  // Config capture, progress counters and the registered region write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_base     <= '0;
      r_len      <= '0;
      r_total    <= '0;
      r_issued   <= '0;
      r_written  <= '0;
      r_line_idx <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      if (w_launch) begin
        r_base     <= configreg[LOG2_DEPTH-1:0];
        r_len      <= configreg[31:16];
        r_total    <= w_total_in;
        r_issued   <= '0;
        r_written  <= '0;
        r_line_idx <= '0;
      end else begin
        if (fifo_re) begin
          r_issued <= r_issued + 32'd1;
        end
        if (r_we) begin
          r_written <= r_written + 32'd1;
        end
        if (w_accept) begin
          r_line_idx <= (w_line_inc == r_len) ? 16'd0 : w_line_inc;
        end
      end
      r_we <= w_accept;
      if (w_accept) begin
        // Address wraps naturally modulo the region size.
        r_waddr <= r_base + r_line_idx[LOG2_DEPTH-1:0];
        r_wdata <= fifo_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fifo2write_region.sv
// tb_fifo2write_region: directed scoreboard bench for fifo2write_region.
// A FIFO model answers reads with one cycle of latency; expected writes are
// queued by the stimulus and popped by an independent monitor.
module tb_fifo2write_region;
  localparam int WIDTH      = 512;
  localparam int LOG2_DEPTH = 10;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  op_start;
  logic [31:0]           configreg;
  logic [15:0]           iterations;
  logic                  fifo_re;
  logic                  fifo_rvalid;
  logic [WIDTH-1:0]      fifo_rdata;
  logic                  fifo_empty;
  logic                  region_we;
  logic [LOG2_DEPTH-1:0] region_waddr;
  logic [WIDTH-1:0]      region_wdata;
  logic                  busy;
  logic                  op_done;

  fifo2write_region #(.WIDTH(WIDTH), .LOG2_DEPTH(LOG2_DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .op_start     (op_start),
    .configreg    (configreg),
    .iterations   (iterations),
    .fifo_re      (fifo_re),
    .fifo_rvalid  (fifo_rvalid),
    .fifo_rdata   (fifo_rdata),
    .fifo_empty   (fifo_empty),
    .region_we    (region_we),
    .region_waddr (region_waddr),
    .region_wdata (region_wdata),
    .busy         (busy),
    .op_done      (op_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LOG2_DEPTH-1:0] addr;
    logic [WIDTH-1:0]      data;
  } wr_t;

  wr_t              sb[$];
  logic [WIDTH-1:0] fifo_q[$];
  int               we_cyc[$];
  int               re_cyc[$];

  int checks      = 0;
  int failures    = 0;
  int cyc         = 0;
  int we_count    = 0;
  int re_count    = 0;
  int done_count  = 0;
  int busy_count  = 0;
  int stray_req   = 0;
  int stray_done  = 0;
  bit zero_mode   = 1'b0;
  logic done_busy = 1'b0;

  function automatic logic [WIDTH-1:0] mkdata(input int t, input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 ^ 32'(t * 256 + i);
    return {16{w}};
  endfunction

  // FIFO model: read enable seen in a cycle returns data in the next cycle.
  initial begin
    logic re_q;
    re_q        = 1'b0;
    fifo_rvalid = 1'b0;
    fifo_rdata  = '0;
    fifo_empty  = 1'b1;
    forever begin
      @(negedge clk);
      re_q = fifo_re;
      @(posedge clk);
      #1;
      if (re_q) begin
        checks++;
        if (fifo_q.size() == 0) begin
          failures++;
          $display("FAIL fifo_underflow: read issued with %0d entries, required >=1", fifo_q.size());
          fifo_rvalid = 1'b0;
        end else begin
          fifo_rvalid = 1'b1;
          fifo_rdata  = fifo_q.pop_front();
        end
      end else if (stray_req != stray_done) begin
        fifo_rvalid = 1'b1;
        fifo_rdata  = mkdata(99, 0);
        stray_done++;
      end else begin
        fifo_rvalid = 1'b0;
      end
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  // Monitor: scoreboard pops on every region write, op_done timing check.
  initial begin
    bit  done_due;
    wr_t e;
    done_due = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (fifo_re) begin
        re_count++;
        re_cyc.push_back(cyc);
      end
      if (busy) busy_count++;
      if (!zero_mode && (op_done || done_due)) begin
        checks++;
        if (op_done !== done_due) begin
          failures++;
          $display("FAIL op_done_timing: op_done=%0b required=%0b at cycle %0d", op_done, done_due, cyc);
        end
      end
      if (op_done) begin
        done_count++;
        done_busy = busy;
      end
      done_due = 1'b0;
      if (region_we) begin
        we_count++;
        we_cyc.push_back(cyc);
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: addr=0x%0h data=0x%0h, required no write", region_waddr, region_wdata[31:0]);
        end else begin
          e = sb.pop_front();
          if (region_waddr !== e.addr || region_wdata !== e.data) begin
            failures++;
            $display("FAIL write_data: addr=0x%0h data=0x%0h, required addr=0x%0h data=0x%0h",
                     region_waddr, region_wdata[31:0], e.addr, e.data[31:0]);
          end
          if (sb.size() == 0) done_due = 1'b1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input int addr, input logic [WIDTH-1:0] data);
    wr_t e;
    e.addr = addr[LOG2_DEPTH-1:0];
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic start_op(input logic [15:0] base, input logic [15:0] len, input logic [15:0] iter);
    configreg  = {len, base};
    iterations = iter;
    op_start   = 1'b1;
    tick(1);
    op_start   = 1'b0;
  endtask

  task automatic wait_done(input int max, input string name);
    int d0;
    int n;
    d0 = done_count;
    n  = 0;
    while (done_count == d0 && n < max) begin
      tick(1);
      n++;
    end
    checks++;
    if (done_count == d0) begin
      failures++;
      $display("FAIL %s_done_timeout: no op_done within %0d cycles, required one", name, max);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int b_we, b_re, b_done, b_busy, wi, ri, n;

    reset      = 1'b1;
    op_start   = 1'b0;
    configreg  = '0;
    iterations = '0;
    tick(3);
    chk("rst_fifo_re", 64'(fifo_re), 64'd0);
    chk("rst_region_we", 64'(region_we), 64'd0);
    chk("rst_region_waddr", 64'(region_waddr), 64'd0);
    chk("rst_region_wdata", 64'(|region_wdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_op_done", 64'(op_done), 64'd0);
    reset = 1'b0;
    tick(2);

    // Base 0x010, four lines, one pass, FIFO pre-filled.
    for (int i = 0; i < 4; i++) begin
      fifo_q.push_back(mkdata(1, i));
      exp_wr(16'h010 + i, mkdata(1, i));
    end
    tick(2);
    b_we = we_count; b_re = re_count; b_busy = busy_count;
    wi = we_cyc.size(); ri = re_cyc.size();
    start_op(16'h0010, 16'd4, 16'd1);
    chk("t1_busy_after_start", 64'(busy), 64'd1);
    wait_done(50, "t1");
    chk("t1_we_count", 64'(we_count - b_we), 64'd4);
    chk("t1_re_count", 64'(re_count - b_re), 64'd4);
    chk("t1_busy_cycles", 64'(busy_count - b_busy), 64'd6);
    chk("t1_busy_at_done", 64'(done_busy), 64'd0);
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);
    if (we_cyc.size() >= wi + 4 && re_cyc.size() >= ri + 4) begin
      chk("t1_re_to_we_latency", 64'(we_cyc[wi] - re_cyc[ri]), 64'd2);
      chk("t1_re_consecutive", 64'(re_cyc[ri+3] - re_cyc[ri]), 64'd3);
      chk("t1_we_consecutive", 64'(we_cyc[wi+3] - we_cyc[wi]), 64'd3);
    end

    // Base 0x3FE, four lines, two passes: wrap at top of region, surplus left.
    for (int i = 0; i < 10; i++) fifo_q.push_back(mkdata(2, i));
    for (int i = 0; i < 8; i++) exp_wr((16'h3FE + (i % 4)) & 16'h3FF, mkdata(2, i));
    tick(2);
    b_we = we_count; b_re = re_count;
    start_op(16'h03FE, 16'd4, 16'd2);
    wait_done(60, "t2");
    chk("t2_we_count", 64'(we_count - b_we), 64'd8);
    chk("t2_re_count", 64'(re_count - b_re), 64'd8);
    chk("t2_fifo_surplus", 64'(fifo_q.size()), 64'd2);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);
    fifo_q.delete();
    tick(2);

    // Trickle feed: one entry every three cycles, five lines at base 0.
    b_we = we_count; b_done = done_count; wi = we_cyc.size();
    start_op(16'h0000, 16'd5, 16'd1);
    chk("t3_busy_while_starved", 64'(busy), 64'd1);
    for (int i = 0; i < 5; i++) begin
      fifo_q.push_back(mkdata(3, i));
      exp_wr(i, mkdata(3, i));
      tick(3);
    end
    wait_done(60, "t3");
    tick(5);
    chk("t3_we_count", 64'(we_count - b_we), 64'd5);
    chk("t3_done_count", 64'(done_count - b_done), 64'd1);
    chk("t3_sb_empty", 64'(sb.size()), 64'd0);
    if (we_cyc.size() >= wi + 5) begin
      chk("t3_we_spacing", 64'(we_cyc[wi+4] - we_cyc[wi]), 64'd12);
    end

    // Zero-length operations complete at once without touching the FIFO.
    zero_mode = 1'b1;
    fifo_q.push_back(mkdata(4, 0));
    fifo_q.push_back(mkdata(4, 1));
    tick(2);
    b_we = we_count; b_re = re_count;
    start_op(16'h0005, 16'd0, 16'd3);
    chk("t4_len0_done", 64'(op_done), 64'd1);
    chk("t4_len0_busy", 64'(busy), 64'd0);
    tick(1);
    chk("t4_len0_done_drop", 64'(op_done), 64'd0);
    start_op(16'h0005, 16'd7, 16'd0);
    chk("t4_iter0_done", 64'(op_done), 64'd1);
    chk("t4_iter0_busy", 64'(busy), 64'd0);
    tick(3);
    chk("t4_we_count", 64'(we_count - b_we), 64'd0);
    chk("t4_re_count", 64'(re_count - b_re), 64'd0);
    chk("t4_fifo_untouched", 64'(fifo_q.size()), 64'd2);
    zero_mode = 1'b0;
    fifo_q.delete();
    tick(2);

    // Second op_start while running is ignored.
    for (int i = 0; i < 8; i++) begin
      fifo_q.push_back(mkdata(5, i));
      exp_wr(16'h020 + i, mkdata(5, i));
    end
    tick(2);
    b_we = we_count; b_re = re_count; b_done = done_count;
    start_op(16'h0020, 16'd8, 16'd1);
    tick(3);
    start_op(16'h0100, 16'd2, 16'd1);
    wait_done(60, "t5");
    tick(5);
    chk("t5_we_count", 64'(we_count - b_we), 64'd8);
    chk("t5_re_count", 64'(re_count - b_re), 64'd8);
    chk("t5_done_count", 64'(done_count - b_done), 64'd1);
    chk("t5_sb_empty", 64'(sb.size()), 64'd0);

    // Reset after three writes, with op_start asserted alongside reset.
    for (int i = 0; i < 8; i++) begin
      fifo_q.push_back(mkdata(6, i));
      exp_wr(16'h040 + i, mkdata(6, i));
    end
    tick(2);
    b_we = we_count;
    start_op(16'h0040, 16'd8, 16'd1);
    n = 0;
    while (we_count - b_we < 3 && n < 40) begin
      tick(1);
      n++;
    end
    chk("t6_reached_three_writes", 64'(we_count - b_we >= 3), 64'd1);
    reset      = 1'b1;
    op_start   = 1'b1;
    configreg  = {16'd2, 16'h0000};
    iterations = 16'd1;
    tick(1);
    chk("t6_rst_fifo_re", 64'(fifo_re), 64'd0);
    chk("t6_rst_region_we", 64'(region_we), 64'd0);
    chk("t6_rst_region_waddr", 64'(region_waddr), 64'd0);
    chk("t6_rst_region_wdata", 64'(|region_wdata), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_op_done", 64'(op_done), 64'd0);
    reset    = 1'b0;
    op_start = 1'b0;
    tick(1);
    chk("t6_start_during_reset_ignored", 64'(busy), 64'd0);
    sb.delete();
    b_we = we_count; b_done = done_count;
    tick(6);
    chk("t6_no_writes_after_reset", 64'(we_count - b_we), 64'd0);
    chk("t6_no_done_after_reset", 64'(done_count - b_done), 64'd0);
    fifo_q.delete();
    tick(2);
    for (int i = 0; i < 3; i++) begin
      fifo_q.push_back(mkdata(7, i));
      exp_wr(16'h040 + i, mkdata(7, i));
    end
    tick(2);
    b_we = we_count;
    start_op(16'h0040, 16'd3, 16'd1);
    wait_done(40, "t6_rerun");
    chk("t6_rerun_we_count", 64'(we_count - b_we), 64'd3);
    chk("t6_rerun_sb_empty", 64'(sb.size()), 64'd0);

    // Stray read-valid while idle must not write.
    b_we = we_count;
    stray_req++;
    tick(5);
    chk("t7_stray_no_write", 64'(we_count - b_we), 64'd0);
    chk("t7_idle_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
